button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Upstream conditioning stage for push-button inputs. Feeds the button counter's count-enable input.
- Synchronizes a raw, bouncing, asynchronous button signal to clk.
- Accepts a level change only after it has been stable for WAIT_CLKS consecutive cycles.
- Emits a clean debounced level plus a single-cycle press pulse, so one physical press increments the counter exactly once.

Parameters:
- WAIT_CLKS, 50000: consecutive stable synchronized samples required to accept a level change. Legal range >= 2. Benches use 4 or 16.
- CNT_W, $clog2(WAIT_CLKS): width of the stability counter. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- btn_in  input  1  raw button, asynchronous to clk, may bounce
- btn_out  output  1  debounced button level
- btn_pulse  output  1  one-cycle strobe when a press is accepted
- btn_release  output  1  one-cycle strobe when a release is accepted

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - sync flops s1 and s2 = 0
  - state = S_LOW, counter = 0
  - btn_out, btn_pulse and btn_release = 0
- Synchronizer: two-flop chain btn_in -> s1 -> s2. Only s2 is used by the FSM.
- FSM states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
  - S_LOW: if s2=1, go to S_WAIT_HIGH and set counter=0. Otherwise stay.
  - S_WAIT_HIGH:
    - if s2=0, return to S_LOW (glitch rejected, no outputs change)
    - else if counter == WAIT_CLKS-1, go to S_HIGH
    - else counter++
  - S_HIGH: if s2=0, go to S_WAIT_LOW and set counter=0. Otherwise stay.
  - S_WAIT_LOW: mirror of S_WAIT_HIGH.
    - if s2=1, return to S_HIGH
    - else if counter == WAIT_CLKS-1, go to S_LOW
    - else counter++
- Outputs are all registered; no combinational path from btn_in.
  - btn_out = 1 in S_HIGH and S_WAIT_LOW, 0 otherwise.
  - btn_pulse = 1 for exactly the one cycle following the S_WAIT_HIGH->S_HIGH transition.
  - btn_release = 1 for exactly the one cycle following the S_WAIT_LOW->S_LOW transition.
- Latency, with btn_in rising before edge 1 and held high:
  - s2 = 1 after edge 2
  - S_WAIT_HIGH entered at edge 3
  - S_HIGH entered at edge WAIT_CLKS+3
  - btn_out and btn_pulse go high after that edge.
  - Release latency is identical.
- Acceptance requires WAIT_CLKS+1 consecutive identical s2 samples, counting the entry sample.
- Any opposite sample during a wait state restarts from the stable state. The counter never saturates or wraps, because it stops at WAIT_CLKS-1.
- btn_pulse and btn_release are never high in the same cycle.
- There is never more than one btn_pulse between two btn_release strobes.
- Reset mid-wait: immediate return to S_LOW with outputs 0. No pulse is emitted for the aborted press.
- Button held through reset deassertion: treated as a new press. btn_pulse fires WAIT_CLKS+3 edges after rst falls.
- X or metastable behaviour on btn_in must not propagate past s2.

Test Plan:
1. WAIT_CLKS=16. rst high 80 ns, released on negedge, btn_in=0 -> btn_out=0, btn_pulse=0, btn_release=0 throughout and after reset.
2. WAIT_CLKS=16. btn_in held high 100 cycles, then low -> btn_out rises after edge 19 from the rise. Exactly one btn_pulse. btn_out falls after edge 19 from the fall, with one btn_release.
3. WAIT_CLKS=16. Bounce pattern high 3, low 2, high 5, low 4, then high 40 cycles -> no pulse during the bounces. Exactly one btn_pulse, 19 edges after the final rise.
4. WAIT_CLKS=16. Isolated 16-cycle-high glitch -> no pulse. 17-cycle-high glitch -> one pulse and one release.
5. WAIT_CLKS=4. 11 presses of random 5-20 cycles high with 25-100 cycles low, then rst, then 17 more presses -> exactly 11, then 17, btn_pulse strobes. A scoreboard counter matches, mirroring the downstream counter's LED value.
6. WAIT_CLKS=16. rst asserted at counter=8 during S_WAIT_HIGH with btn_in still high, released 3 cycles later -> no pulse before reset. One btn_pulse 19 edges after rst deasserts.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a stability FSM that accepts a
// level change only after WAIT_CLKS+1 identical synchronized samples.
module button_debounce #(
  parameter int unsigned WAIT_CLKS = 50000,
  parameter int unsigned CNT_W     = $clog2(WAIT_CLKS)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out,
  output logic btn_pulse,
  output logic btn_release
);

  typedef enum logic [1:0] {StLow, StWaitHigh, StHigh, StWaitLow} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(WAIT_CLKS - 1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_d, pulse_d, release_d;

  // Only s2_q feeds the FSM; s1_q absorbs metastability from the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLow: begin
        if (s2_q) begin
          state_d = StWaitHigh;
          cnt_d   = '0;
        end
      end
      StWaitHigh: begin
        if (!s2_q) begin
          state_d = StLow;
        end else if (cnt_q == CntMax) begin
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHigh: begin
        if (!s2_q) begin
          state_d = StWaitLow;
          cnt_d   = '0;
        end
      end
      StWaitLow: begin
        if (s2_q) begin
          state_d = StHigh;
        end else if (cnt_q == CntMax) begin
          state_d = StLow;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside the transition.
  always_comb begin
    out_d     = (state_d == StHigh) || (state_d == StWaitLow);
    pulse_d   = (state_q == StWaitHigh) && (state_d == StHigh);
    release_d = (state_q == StWaitLow) && (state_d == StLow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLow;
      cnt_q       <= '0;
      btn_out     <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_out     <= out_d;
      btn_pulse   <= pulse_d;
      btn_release <= release_d;
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: WAIT_CLKS=16 and WAIT_CLKS=4 instances, each checked every cycle
// against a run-length model of the acceptance rule, plus directed latency checks.
module tb_button_debounce;

  logic clk;
  logic rst16, btn16, out16, pulse16, rel16;
  logic rst4, btn4, out4, pulse4, rel4;

  int errors = 0;
  int checks = 0;

  button_debounce #(.WAIT_CLKS(16)) dut16 (
    .clk        (clk),
    .rst        (rst16),
    .btn_in     (btn16),
    .btn_out    (out16),
    .btn_pulse  (pulse16),
    .btn_release(rel16)
  );

  button_debounce #(.WAIT_CLKS(4)) dut4 (
    .clk        (clk),
    .rst        (rst4),
    .btn_in     (btn4),
    .btn_out    (out4),
    .btn_pulse  (pulse4),
    .btn_release(rel4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: input reaches the decision point two edges late; the level flips once W+1
  // consecutive samples disagree with it.
  typedef struct {
    logic [1:0] dly;
    int         run;
    logic       lvl;
    logic       pls;
    logic       rls;
    int         npls;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.dly  = 2'b00;
    m.run  = 0;
    m.lvl  = 1'b0;
    m.pls  = 1'b0;
    m.rls  = 1'b0;
    m.npls = 0;
    return m;
  endfunction

  function automatic mdl_t step(input mdl_t m, input logic in, input int w);
    mdl_t n;
    logic smp;
    n     = m;
    smp   = m.dly[1];
    n.dly = {m.dly[0], in};
    n.pls = 1'b0;
    n.rls = 1'b0;
    if (smp == m.lvl) n.run = 0;
    else n.run = m.run + 1;
    if (n.run == w + 1) begin
      n.lvl = smp;
      n.run = 0;
      n.pls = smp;
      n.rls = !smp;
      if (smp) n.npls = m.npls + 1;
    end
    return n;
  endfunction

  mdl_t m16, m4;

  always @(posedge clk or posedge rst16) begin
    if (rst16) m16 <= mdl_reset();
    else m16 <= step(m16, btn16, 16);
  end

  always @(posedge clk or posedge rst4) begin
    if (rst4) m4 <= mdl_reset();
    else m4 <= step(m4, btn4, 4);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Pulse/release counters taken from the DUT, mirroring the downstream counter.
  int cnt16 = 0, rcnt16 = 0, cnt4 = 0;

  always @(posedge clk) begin
    #1;
    chk("out16", out16, m16.lvl);
    chk("pulse16", pulse16, m16.pls);
    chk("release16", rel16, m16.rls);
    chk("out4", out4, m4.lvl);
    chk("pulse4", pulse4, m4.pls);
    chk("release4", rel4, m4.rls);
    if (rst16) begin
      cnt16  = 0;
      rcnt16 = 0;
    end else begin
      if (pulse16 === 1'b1) cnt16++;
      if (rel16 === 1'b1) rcnt16++;
    end
    if (rst4) cnt4 = 0;
    else if (pulse4 === 1'b1) cnt4++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive16(input logic v, input int n);
    btn16 = v;
    tick(n);
  endtask

  task automatic drive4(input logic v, input int n);
    btn4 = v;
    tick(n);
  endtask

  int p0, r0;

  initial begin
    rst16 = 1'b1;
    rst4  = 1'b1;
    btn16 = 1'b0;
    btn4  = 1'b0;

    // Reset behaviour and idle low input.
    #80;
    @(negedge clk);
    rst16 = 1'b0;
    rst4  = 1'b0;
    tick(10);
    chk("idle_out16", out16, 0);
    chk("idle_pulses16", cnt16, 0);

    // Long press: 19-edge latency on both edges.
    p0 = cnt16;
    r0 = rcnt16;
    btn16 = 1'b1;
    tick(18);
    chk("rise_not_yet", out16, 0);
    tick(1);
    chk("rise_out", out16, 1);
    chk("rise_pulse", pulse16, 1);
    tick(1);
    chk("rise_pulse_gone", pulse16, 0);
    tick(80);
    btn16 = 1'b0;
    tick(18);
    chk("fall_not_yet", out16, 1);
    tick(1);
    chk("fall_out", out16, 0);
    chk("fall_release", rel16, 1);
    tick(1);
    chk("long_pulses", cnt16 - p0, 1);
    chk("long_releases", rcnt16 - r0, 1);
    tick(10);

    // Bounce then settle high.
    p0 = cnt16;
    drive16(1'b1, 3);
    drive16(1'b0, 2);
    drive16(1'b1, 5);
    drive16(1'b0, 4);
    btn16 = 1'b1;
    tick(18);
    chk("bounce_no_pulse", cnt16 - p0, 0);
    tick(1);
    chk("bounce_pulse", pulse16, 1);
    tick(21);
    drive16(1'b0, 30);
    chk("bounce_pulses", cnt16 - p0, 1);

    // Glitch width boundary: 16 rejected, 17 accepted.
    p0 = cnt16;
    r0 = rcnt16;
    drive16(1'b1, 16);
    drive16(1'b0, 30);
    chk("glitch16_pulses", cnt16 - p0, 0);
    drive16(1'b1, 17);
    drive16(1'b0, 30);
    chk("glitch17_pulses", cnt16 - p0, 1);
    chk("glitch17_releases", rcnt16 - r0, 1);

    // Random presses on the short-wait instance, with a reset between batches.
    for (int i = 0; i < 11; i++) begin
      drive4(1'b1, int'($urandom_range(20, 5)));
      drive4(1'b0, int'($urandom_range(100, 25)));
    end
    chk("batch1_dut", cnt4, 11);
    chk("batch1_model", m4.npls, 11);
    @(negedge clk);
    rst4 = 1'b1;
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
    tick(1);
    chk("batch_reset", cnt4, 0);
    for (int i = 0; i < 17; i++) begin
      drive4(1'b1, int'($urandom_range(20, 5)));
      drive4(1'b0, int'($urandom_range(100, 25)));
    end
    chk("batch2_dut", cnt4, 17);
    chk("batch2_model", m4.npls, 17);

    // Reset mid-wait with the button still held.
    p0 = cnt16;
    btn16 = 1'b1;
    tick(11);
    chk("midwait_no_pulse", cnt16 - p0, 0);
    @(negedge clk);
    rst16 = 1'b1;
    #1;
    chk("midwait_rst_out", out16, 0);
    repeat (3) @(negedge clk);
    rst16 = 1'b0;
    tick(18);
    chk("after_rst_no_pulse", cnt16, 0);
    tick(1);
    chk("after_rst_pulse", pulse16, 1);
    chk("after_rst_out", out16, 1);
    drive16(1'b0, 30);
    chk("after_rst_pulses", cnt16, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
